mic_capture_ctrl: RTL and testbench

//  Sequences one microphone capture burst: writes CAP_LEN I2S samples into the L/R sample FIFOs,

---
 rtl/mic_capture_ctrl_if.sv | 28 ++
 rtl/mic_capture_ctrl.sv | 110 +++++++++++
 tb/tb_mic_capture_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mic_capture_ctrl_if.sv
// Control/handshake bundle between the capture sequencer, the sample FIFOs and the UART.
interface mic_capture_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             ws_in;
  logic             fifo_full;
  logic             fifo_empty;
  logic             tx_ready;
  logic             fifo_wr_en;
  logic             fifo_rd_en;
  logic             uart_ena;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] cap_count;

  modport master (
    input  start, abort, ws_in, fifo_full, fifo_empty, tx_ready,
    output fifo_wr_en, fifo_rd_en, uart_ena, busy, done, overflow, cap_count
  );

  modport slave (
    output start, abort, ws_in, fifo_full, fifo_empty, tx_ready,
    input  fifo_wr_en, fifo_rd_en, uart_ena, busy, done, overflow, cap_count
  );
endinterface

// File: rtl/mic_capture_ctrl.sv
// Sequences one microphone capture burst: CAP_LEN word-select-aligned FIFO writes,
// then drains the FIFOs through the UART until the read side has been empty for DRAIN_IDLE cycles.
module mic_capture_ctrl #(
  parameter int unsigned CAP_LEN     = 1024,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DRAIN_IDLE  = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  mic_capture_ctrl_if.master   bus
);

  localparam int unsigned IDLE_W = $clog2(DRAIN_IDLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic                   ws_d;
  logic                   ws_rise;
  logic [IDLE_W-1:0]      idle_cnt;

  // Word-select synchroniser and rising-edge detect
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ws_sync <= '0;
      ws_d    <= 1'b0;
    end else begin
      ws_sync <= {ws_sync[SYNC_STAGES-2:0], bus.ws_in};
      ws_d    <= ws_sync[SYNC_STAGES-1];
    end
  end

  assign ws_rise = ws_sync[SYNC_STAGES-1] & ~ws_d;

  // The final capture write lands in the first DRAIN cycle, so reads are held off for that cycle
  assign bus.uart_ena   = (state == S_DRAIN) & ~bus.fifo_empty;
  assign bus.fifo_rd_en = (state == S_DRAIN) & bus.tx_ready & ~bus.fifo_empty & ~bus.fifo_wr_en;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= S_IDLE;
      bus.fifo_wr_en <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.cap_count <= '0;
      idle_cnt      <= '0;
    end else begin
      bus.fifo_wr_en <= 1'b0;
      bus.done       <= 1'b0;
      if (bus.abort) begin
        state    <= S_IDLE;
        bus.busy <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.start) begin
              state         <= S_ARM;
              bus.busy      <= 1'b1;
              bus.cap_count <= '0;
              bus.overflow  <= 1'b0;
            end
          end
          // First edge only aligns the burst to a frame boundary
          S_ARM: begin
            if (ws_rise) state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            if (ws_rise) begin
              if (!bus.fifo_full) bus.fifo_wr_en <= 1'b1;
              else                bus.overflow   <= 1'b1;
              if (bus.cap_count < CNT_W'(CAP_LEN)) bus.cap_count <= bus.cap_count + CNT_W'(1);
              if (bus.cap_count >= CNT_W'(CAP_LEN - 1)) begin
                state    <= S_DRAIN;
                idle_cnt <= '0;
              end
            end
          end
          S_DRAIN: begin
            if (bus.fifo_empty) begin
              if (idle_cnt == IDLE_W'(DRAIN_IDLE - 1)) begin
                state    <= S_DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
              end
            end else begin
              idle_cnt <= '0;
            end
          end
          S_DONE: state <= S_IDLE;
          default: begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl with CAP_LEN=8: reset, nominal burst, overflow,
// drain gap, abort and ignored start.
module tb_mic_capture_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   wr_count = 0;
  int   rd_count = 0;
  int   done_count = 0;
  int   both_seen = 0;
  int   wr_base, rd_base, done_base;

  always #5 clk = ~clk;

  mic_capture_ctrl_if #(.CNT_W(16)) bus ();

  mic_capture_ctrl #(
    .CAP_LEN(8), .CNT_W(16), .SYNC_STAGES(2), .DRAIN_IDLE(16)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  // Strobe monitor: counts each cycle a strobe is high
  always @(posedge clk) begin
    if (bus.fifo_wr_en === 1'b1) wr_count++;
    if (bus.fifo_rd_en === 1'b1) rd_count++;
    if (bus.done === 1'b1) done_count++;
    if (bus.fifo_wr_en === 1'b1 && bus.fifo_rd_en === 1'b1) both_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word-select frame; the write strobe must appear exactly 3 cycles after the rise
  task automatic ws_frame(input string tag, input logic exp_wr);
    bus.ws_in = 1'b1;
    tick();
    tick();
    chk({tag, " pre"}, 32'(bus.fifo_wr_en), 32'd0);
    tick();
    chk({tag, " wr"}, 32'(bus.fifo_wr_en), 32'(exp_wr));
    bus.ws_in = 1'b0;
    tick();
    chk({tag, " post"}, 32'(bus.fifo_wr_en), 32'd0);
    tick();
    tick();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " busy@done"}, 32'(bus.busy), 32'd0);
    tick();
  endtask

  task automatic start_burst();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b1;
    bus.abort      = 1'b0;
    bus.ws_in      = 1'b0;
    bus.fifo_full  = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.tx_ready   = 1'b0;

    // T1: reset held with start and toggling ws
    for (int i = 0; i < 6; i++) begin
      bus.ws_in = ~bus.ws_in;
      tick();
    end
    chk("t1 strobes", 32'({bus.fifo_wr_en, bus.fifo_rd_en, bus.uart_ena, bus.busy, bus.done, bus.overflow}), 32'd0);
    chk("t1 cap_count", 32'(bus.cap_count), 32'd0);
    chk("t1 wr_count", 32'(wr_count), 32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t1 idle busy", 32'(bus.busy), 32'd0);

    // T2: nominal burst
    wr_base = wr_count; rd_base = rd_count; done_base = done_count;
    start_burst();
    chk("t2 busy arm", 32'(bus.busy), 32'd1);
    chk("t2 cap0", 32'(bus.cap_count), 32'd0);
    ws_frame("t2 skip", 1'b0);
    for (int i = 0; i < 8; i++) ws_frame("t2 frame", 1'b1);
    chk("t2 cap_count", 32'(bus.cap_count), 32'd8);
    chk("t2 writes", 32'(wr_count - wr_base), 32'd8);
    chk("t2 busy drain", 32'(bus.busy), 32'd1);
    bus.fifo_empty = 1'b0;
    #1;
    chk("t2 uart_ena", 32'(bus.uart_ena), 32'd1);
    chk("t2 rd idle", 32'(bus.fifo_rd_en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.tx_ready = 1'b1;
      #1;
      chk("t2 rd", 32'(bus.fifo_rd_en), 32'd1);
      tick();
      bus.tx_ready = 1'b0;
    end
    bus.fifo_empty = 1'b1;
    #1;
    chk("t2 uart_ena off", 32'(bus.uart_ena), 32'd0);
    chk("t2 reads", 32'(rd_count - rd_base), 32'd8);
    repeat (15) tick();
    chk("t2 busy @15", 32'(bus.busy), 32'd1);
    chk("t2 done @15", 32'(bus.done), 32'd0);
    tick();
    chk("t2 done @16", 32'(bus.done), 32'd1);
    tick();
    chk("t2 done cleared", 32'(bus.done), 32'd0);
    chk("t2 busy idle", 32'(bus.busy), 32'd0);
    chk("t2 done once", 32'(done_count - done_base), 32'd1);
    chk("t2 overflow", 32'(bus.overflow), 32'd0);

    // T3: FIFO full during edges 3..4
    wr_base = wr_count;
    start_burst();
    ws_frame("t3 skip", 1'b0);
    for (int i = 1; i <= 8; i++) begin
      bus.fifo_full = (i == 3 || i == 4);
      ws_frame("t3 frame", !(i == 3 || i == 4));
    end
    bus.fifo_full = 1'b0;
    chk("t3 writes", 32'(wr_count - wr_base), 32'd6);
    chk("t3 overflow", 32'(bus.overflow), 32'd1);
    chk("t3 cap_count", 32'(bus.cap_count), 32'd8);
    chk("t3 busy drain", 32'(bus.busy), 32'd1);
    wait_done("t3");
    chk("t3 overflow sticky", 32'(bus.overflow), 32'd1);

    // T4: short empty gap in DRAIN does not end the burst
    done_base = done_count;
    start_burst();
    chk("t4 overflow cleared", 32'(bus.overflow), 32'd0);
    ws_frame("t4 skip", 1'b0);
    for (int i = 0; i < 8; i++) ws_frame("t4 frame", 1'b1);
    bus.fifo_empty = 1'b0;
    repeat (2) tick();
    bus.fifo_empty = 1'b1;
    repeat (5) tick();
    bus.fifo_empty = 1'b0;
    tick();
    chk("t4 gap busy", 32'(bus.busy), 32'd1);
    chk("t4 gap no done", 32'(done_count - done_base), 32'd0);
    bus.fifo_empty = 1'b1;
    repeat (15) tick();
    chk("t4 busy @15", 32'(bus.busy), 32'd1);
    chk("t4 done @15", 32'(bus.done), 32'd0);
    tick();
    chk("t4 done @16", 32'(bus.done), 32'd1);
    tick();
    chk("t4 busy after", 32'(bus.busy), 32'd0);
    chk("t4 done once", 32'(done_count - done_base), 32'd1);

    // T5: abort coincident with the 4th capture edge
    wr_base = wr_count; done_base = done_count;
    start_burst();
    ws_frame("t5 skip", 1'b0);
    for (int i = 0; i < 3; i++) ws_frame("t5 frame", 1'b1);
    chk("t5 cap3", 32'(bus.cap_count), 32'd3);
    bus.ws_in = 1'b1;
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5 no write", 32'(bus.fifo_wr_en), 32'd0);
    chk("t5 busy", 32'(bus.busy), 32'd0);
    chk("t5 cap held", 32'(bus.cap_count), 32'd3);
    bus.ws_in = 1'b0;
    repeat (3) tick();
    ws_frame("t5 after", 1'b0);
    chk("t5 writes", 32'(wr_count - wr_base), 32'd3);
    chk("t5 no done", 32'(done_count - done_base), 32'd0);
    chk("t5 cap still", 32'(bus.cap_count), 32'd3);

    // T6: start ignored during CAPTURE and DRAIN
    start_burst();
    ws_frame("t6 skip", 1'b0);
    for (int i = 0; i < 2; i++) ws_frame("t6 frame", 1'b1);
    start_burst();
    chk("t6 cap capture", 32'(bus.cap_count), 32'd2);
    chk("t6 busy capture", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 6; i++) ws_frame("t6 frame2", 1'b1);
    start_burst();
    chk("t6 cap drain", 32'(bus.cap_count), 32'd8);
    chk("t6 busy drain", 32'(bus.busy), 32'd1);
    wait_done("t6");

    chk("wr/rd exclusive", 32'(both_seen), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
